multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 24-bit CPU datapath: sequences fetch, decode, execute, memory and writeback.

---
 rtl/cpu24_pkg.sv | 27 ++
 rtl/seq_wait_timer.sv | 28 ++
 rtl/multicycle_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu24_pkg.sv
// Shared encodings for the 24-bit CPU control path: opcodes, ALU selects, sequencer states.
package cpu24_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0110;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LS    = 4'b0010;
    localparam logic [3:0] OP_SS    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_RT  = 2'b00;
    localparam logic [1:0] ALUB_ONE = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;
    localparam logic [1:0] ALUB_BR  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_MUL_GO, S_MUL_WAIT, S_WB_M,
        S_EXEC_I, S_WB_I, S_ADDR, S_MEM_RD, S_WB_L, S_MEM_WR, S_BRANCH, S_TRAP
    } seqState_t;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts cycles spent waiting on memory or the multiplier; flags when the limit is reached.
module seq_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

    logic [7:0] count;

    // Count holds at the limit so a stalled state never wraps back to a small value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 8'd1;
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback, with wait timeouts and traps.
module multicycle_sequencer
    import cpu24_pkg::*;
#(
    parameter int                 FUNCT_W   = 3,
    parameter logic [FUNCT_W-1:0] MUL_FUNCT = 3'b011,
    parameter int                 WAIT_MAX  = 255
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [3:0]         Opcode,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               Zero,
    input  logic               MemReady,
    input  logic               MulDone,
    output logic               PcWrite,
    output logic               PcWriteCond,
    output logic [1:0]         PcSource,
    output logic               IorD,
    output logic               IrWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               MulSel,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [1:0]         AluOp,
    output logic               MulStart,
    output logic               Retire,
    output logic               Illegal,
    output logic               BusError
);

    seqState_t state, nextState;
    logic      setIllegal, setBusError;
    logic      illegalFlag, busErrorFlag;
    logic      waiting, expired;

    // The branch decision is made in the datapath from PcWriteCond and Zero.
    logic unusedZero;
    assign unusedZero = Zero;

    assign waiting = (state == S_FETCH) || (state == S_MEM_RD) ||
                     (state == S_MEM_WR) || (state == S_MUL_WAIT);

    seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) uTimer (
        .clock   (Clock),
        .reset   (Reset),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= nextState;
    end

    // Sticky trap causes, cleared only by reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            illegalFlag  <= 1'b0;
            busErrorFlag <= 1'b0;
        end else begin
            if (setIllegal)  illegalFlag  <= 1'b1;
            if (setBusError) busErrorFlag <= 1'b1;
        end
    end

    // Next-state and strobe decode; strobes that commit a fetch or store are gated by MemReady.
    always_comb begin
        nextState   = state;
        setIllegal  = 1'b0;
        setBusError = 1'b0;
        PcWrite     = 1'b0;
        PcWriteCond = 1'b0;
        PcSource    = PCSRC_ALU;
        IorD        = 1'b0;
        IrWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        MulSel      = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = ALUB_RT;
        AluOp       = ALUOP_ADD;
        MulStart    = 1'b0;
        Retire      = 1'b0;
        unique case (state)
            S_IDLE: nextState = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IrWrite   = 1'b1;
                    PcWrite   = 1'b1;
                    AluSrcB   = ALUB_ONE;
                    nextState = S_DECODE;
                end else if (expired) begin
                    setBusError = 1'b1;
                    nextState   = S_TRAP;
                end
            end
            S_DECODE: begin
                AluSrcB = ALUB_BR;
                case (Opcode)
                    OP_RTYPE: nextState = (Funct == MUL_FUNCT) ? S_MUL_GO : S_EXEC_R;
                    OP_ADDI:  nextState = S_EXEC_I;
                    OP_LS,
                    OP_SS:    nextState = S_ADDR;
                    OP_BEQ:   nextState = S_BRANCH;
                    default: begin
                        setIllegal = 1'b1;
                        nextState  = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R: begin
                AluSrcA   = 1'b1;
                AluOp     = ALUOP_FUNCT;
                nextState = S_WB_R;
            end
            S_WB_R: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
                nextState = S_FETCH;
            end
            S_MUL_GO: begin
                MulStart  = 1'b1;
                nextState = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (MulDone) begin
                    nextState = S_WB_M;
                end else if (expired) begin
                    setBusError = 1'b1;
                    nextState   = S_TRAP;
                end
            end
            S_WB_M: begin
                RegDst    = 1'b1;
                MulSel    = 1'b1;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
                nextState = S_FETCH;
            end
            S_EXEC_I: begin
                AluSrcA   = 1'b1;
                AluSrcB   = ALUB_IMM;
                nextState = S_WB_I;
            end
            S_WB_I: begin
                RegWrite  = 1'b1;
                Retire    = 1'b1;
                nextState = S_FETCH;
            end
            S_ADDR: begin
                AluSrcA   = 1'b1;
                AluSrcB   = ALUB_IMM;
                nextState = (Opcode == OP_SS) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    nextState = S_WB_L;
                end else if (expired) begin
                    setBusError = 1'b1;
                    nextState   = S_TRAP;
                end
            end
            S_WB_L: begin
                MemToReg  = 1'b1;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
                nextState = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    Retire    = 1'b1;
                    nextState = S_FETCH;
                end else if (expired) begin
                    setBusError = 1'b1;
                    nextState   = S_TRAP;
                end
            end
            S_BRANCH: begin
                AluSrcA     = 1'b1;
                AluOp       = ALUOP_SUB;
                PcWriteCond = 1'b1;
                PcSource    = PCSRC_ALUOUT;
                Retire      = 1'b1;
                nextState   = S_FETCH;
            end
            S_TRAP: nextState = S_TRAP;
            default: nextState = S_TRAP;
        endcase
    end

    assign Illegal  = illegalFlag;
    assign BusError = busErrorFlag;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected strobe traces driven with random waits and opcodes.
module tb_multicycle_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Opcode = 4'd0;
    logic [2:0] Funct = 3'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       MulDone = 1'b0;
    logic       PcWrite, PcWriteCond, IorD, IrWrite, MemRead, MemWrite, MemToReg, MulSel;
    logic       RegDst, RegWrite, AluSrcA, MulStart, Retire, Illegal, BusError;
    logic [1:0] PcSource, AluSrcB, AluOp;

    int compared = 0;
    int mismatched = 0;

    multicycle_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .MulDone(MulDone),
        .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .PcSource(PcSource), .IorD(IorD),
        .IrWrite(IrWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .MulSel(MulSel), .RegDst(RegDst), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluOp(AluOp), .MulStart(MulStart), .Retire(Retire),
        .Illegal(Illegal), .BusError(BusError)
    );

    always #5 Clock = ~Clock;

    // Observed strobes packed into one word; each constant below names one strobe field value.
    logic [20:0] obs;
    assign obs = {PcWrite, PcWriteCond, PcSource, IorD, IrWrite, MemRead, MemWrite, MemToReg,
                  MulSel, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, MulStart, Retire,
                  Illegal, BusError};

    localparam logic [20:0] NONE    = 21'd0;
    localparam logic [20:0] PCW     = 21'd1 << 20;
    localparam logic [20:0] PCWC    = 21'd1 << 19;
    localparam logic [20:0] PCS_BR  = 21'd1 << 17;
    localparam logic [20:0] IORD    = 21'd1 << 16;
    localparam logic [20:0] IRW     = 21'd1 << 15;
    localparam logic [20:0] MRD     = 21'd1 << 14;
    localparam logic [20:0] MWR     = 21'd1 << 13;
    localparam logic [20:0] M2R     = 21'd1 << 12;
    localparam logic [20:0] MSEL    = 21'd1 << 11;
    localparam logic [20:0] RDST    = 21'd1 << 10;
    localparam logic [20:0] RW      = 21'd1 << 9;
    localparam logic [20:0] ASA     = 21'd1 << 8;
    localparam logic [20:0] ASB_ONE = 21'd1 << 6;
    localparam logic [20:0] ASB_IMM = 21'd2 << 6;
    localparam logic [20:0] ASB_BR  = 21'd3 << 6;
    localparam logic [20:0] AOP_SUB = 21'd1 << 4;
    localparam logic [20:0] AOP_FN  = 21'd2 << 4;
    localparam logic [20:0] MST     = 21'd1 << 3;
    localparam logic [20:0] RET     = 21'd1 << 2;
    localparam logic [20:0] ILL     = 21'd1 << 1;
    localparam logic [20:0] BER     = 21'd1;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input logic [20:0] expected, input string tag);
        compared++;
        assert (obs === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expected);
        end
    endtask

    // One clock cycle: drive handshakes, compare on the falling edge, return just after the rising edge.
    task automatic step(input logic [20:0] expected, input logic rdy, input logic done, input string tag);
        MemReady = rdy;
        MulDone  = done;
        @(negedge Clock);
        check(expected, tag);
        @(posedge Clock);
        #1;
    endtask

    // Assert reset, check strobes drop immediately, release, then expect one idle cycle.
    task automatic doReset();
        Reset = 1'b1;
        #1;
        check(NONE, "reset_asserted");
        @(posedge Clock);
        @(negedge Clock);
        check(NONE, "reset_held");
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        step(NONE, rb(), rb(), "idle");
    endtask

    // Expected strobe trace for one instruction starting in the fetch cycle.
    task automatic runInstr(input logic [3:0] op, input logic [2:0] fn, input logic z,
                            input int fetchWait, input int execWait);
        Opcode = op;
        Funct  = fn;
        Zero   = z;
        for (int i = 0; i < fetchWait; i++) step(MRD, 1'b0, rb(), "fetch_wait");
        step(MRD | IRW | PCW | ASB_ONE, 1'b1, rb(), "fetch_ready");
        step(ASB_BR, rb(), rb(), "decode");
        case (op)
            4'b0110: begin
                if (fn == 3'b011) begin
                    step(MST, rb(), rb(), "mul_go");
                    for (int i = 0; i < execWait; i++) step(NONE, rb(), 1'b0, "mul_wait");
                    step(NONE, rb(), 1'b1, "mul_done");
                    step(RDST | MSEL | RW | RET, rb(), rb(), "wb_mul");
                end else begin
                    step(ASA | AOP_FN, rb(), rb(), "exec_r");
                    step(RDST | RW | RET, rb(), rb(), "wb_r");
                end
            end
            4'b0001: begin
                step(ASA | ASB_IMM, rb(), rb(), "exec_i");
                step(RW | RET, rb(), rb(), "wb_i");
            end
            4'b0010: begin
                step(ASA | ASB_IMM, rb(), rb(), "addr_ld");
                for (int i = 0; i < execWait; i++) step(MRD | IORD, 1'b0, rb(), "mem_rd_wait");
                step(MRD | IORD, 1'b1, rb(), "mem_rd_ready");
                step(M2R | RW | RET, rb(), rb(), "wb_load");
            end
            4'b0011: begin
                step(ASA | ASB_IMM, rb(), rb(), "addr_st");
                for (int i = 0; i < execWait; i++) step(MWR | IORD, 1'b0, rb(), "mem_wr_wait");
                step(MWR | IORD | RET, 1'b1, rb(), "mem_wr_ready");
            end
            4'b0100: step(ASA | AOP_SUB | PCWC | PCS_BR | RET, rb(), rb(), "branch");
            default: begin
                for (int i = 0; i < 4; i++) step(ILL, rb(), rb(), "trap_illegal");
            end
        endcase
    endtask

    logic [3:0] illegalOps [11] = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    initial begin
        logic [3:0] op;
        logic [2:0] fn;
        int         cls;

        doReset();

        // R-type with memory always ready, then directed load / multiply / branch cases.
        runInstr(4'b0110, 3'b000, 1'b0, 0, 0);
        runInstr(4'b0010, 3'b000, 1'b0, 0, 3);
        runInstr(4'b0110, 3'b011, 1'b0, 0, 5);
        runInstr(4'b0100, 3'b000, 1'b1, 0, 0);
        runInstr(4'b0100, 3'b000, 1'b0, 0, 0);
        runInstr(4'b0001, 3'b101, 1'b0, 2, 0);
        runInstr(4'b0011, 3'b000, 1'b0, 1, 2);

        // Illegal opcode parks in trap with Illegal sticky.
        runInstr(4'b1111, 3'b000, 1'b0, 0, 0);
        doReset();

        // Ready arriving in the same cycle the wait limit is reached still completes the fetch.
        runInstr(4'b0001, 3'b000, 1'b0, 255, 0);

        // No ready for the whole wait window: bus error trap with all strobes low.
        for (int i = 0; i < 256; i++) step(MRD, 1'b0, rb(), "fetch_timeout_wait");
        for (int i = 0; i < 3; i++) step(BER, rb(), rb(), "trap_buserr");
        doReset();

        // Reset in the middle of a store: strobes drop at once, then a clean restart.
        Opcode = 4'b0011;
        step(MRD | IRW | PCW | ASB_ONE, 1'b1, 1'b0, "st_fetch");
        step(ASB_BR, 1'b0, 1'b0, "st_decode");
        step(ASA | ASB_IMM, 1'b0, 1'b0, "st_addr");
        step(MWR | IORD, 1'b0, 1'b0, "st_mem_wr_wait");
        MemReady = 1'b1;
        doReset();
        runInstr(4'b0001, 3'b000, 1'b0, 0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            cls = int'($urandom_range(0, 6));
            fn  = 3'($urandom_range(0, 7));
            case (cls)
                0: begin op = 4'b0110; if (fn == 3'b011) fn = 3'b000; end
                1: begin op = 4'b0110; fn = 3'b011; end
                2: op = 4'b0001;
                3: op = 4'b0010;
                4: op = 4'b0011;
                5: op = 4'b0100;
                default: op = illegalOps[$urandom_range(0, 10)];
            endcase
            runInstr(op, fn, rb(), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
            if (cls == 6) doReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
